// File: rtl/fp_pkg.sv
// Shared FP datapath constants and the aligner state type.
// Holds widths, the shift clamp and the align FSM state enum.
package fp_pkg;

    localparam int MANT_W   = 24;
    localparam int SA_W     = 8;
    localparam int GRS_W    = 3;
    localparam int SA_CLAMP = 31;
    localparam int VEC_W    = MANT_W + 2;
    localparam int NSTAGE   = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S16  = 3'd1,
        ST_S8   = 3'd2,
        ST_S4   = 3'd3,
        ST_S2   = 3'd4,
        ST_S1   = 3'd5,
        ST_DONE = 3'd6
    } align_state_t;

endpackage

// File: rtl/align_rshift_stage.sv
// Conditional right shift of the working vector by a constant K.
// Ports: i_vec/i_en in, o_vec out, o_lost (OR of dropped bits,
// present only when ALIGN_STICKY_EN is defined).
module align_rshift_stage
    import fp_pkg::*;
#(
    parameter int K = 1
) (
    input  logic [VEC_W-1:0] i_vec,
    input  logic             i_en,
`ifdef ALIGN_STICKY_EN
    output logic             o_lost,
`endif
    output logic [VEC_W-1:0] o_vec
);

    assign o_vec = i_en ? (i_vec >> K) : i_vec;

`ifdef ALIGN_STICKY_EN
    assign o_lost = i_en & (|i_vec[K-1:0]);
`endif

endmodule

// File: rtl/align_shift_right.sv
// Iterative right-shift aligner: 5 binary-weighted shift steps.
// Ports: clk, rst (sync, active-high); in_valid/in_ready,
// in_mant[24], in_sa[8]; out_valid/out_ready, out_mant[24],
// out_grs[3] {guard,round,sticky}, out_zero.
// Macro ALIGN_STICKY_EN enables the sticky register and OR logic.
module align_shift_right
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [SA_W-1:0]   in_sa,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [GRS_W-1:0]  out_grs,
    output logic              out_zero
);

    align_state_t     r_state, w_state_n;
    logic [VEC_W-1:0] r_vec, w_vec_n;
    logic [4:0]       r_sa, w_sa_n;
    logic [VEC_W-1:0] w_sv [NSTAGE];
    logic [2:0]       w_idx;

`ifdef ALIGN_STICKY_EN
    logic              r_sticky, w_sticky_n;
    logic [NSTAGE-1:0] w_lost;
`endif

    // Stage gi shifts by 16>>gi, enabled by clamped amount bit 4-gi.
    for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage
        align_rshift_stage #(.K(16 >> gi)) u_stage (
            .i_vec  (r_vec),
            .i_en   (r_sa[4-gi]),
`ifdef ALIGN_STICKY_EN
            .o_lost (w_lost[gi]),
`endif
            .o_vec  (w_sv[gi])
        );
    end

    // S16..S1 are encoded 1..5, so state-1 selects the stage.
    assign w_idx = 3'(r_state) - 3'd1;

    always_comb begin
        w_state_n = r_state;
        w_vec_n   = r_vec;
        w_sa_n    = r_sa;
`ifdef ALIGN_STICKY_EN
        w_sticky_n = r_sticky;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_vec_n   = {in_mant, 2'b00};
                    w_sa_n    = (in_sa > SA_W'(SA_CLAMP)) ?
                                5'(SA_CLAMP) : in_sa[4:0];
`ifdef ALIGN_STICKY_EN
                    w_sticky_n = 1'b0;
`endif
                    w_state_n = ST_S16;
                end
            end
            ST_S16, ST_S8, ST_S4, ST_S2, ST_S1: begin
                w_vec_n   = w_sv[w_idx];
`ifdef ALIGN_STICKY_EN
                w_sticky_n = r_sticky | w_lost[w_idx];
`endif
                w_state_n = align_state_t'(3'(r_state) + 3'd1);
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_n = ST_IDLE;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_vec   <= '0;
            r_sa    <= '0;
        end else begin
            r_state <= w_state_n;
            r_vec   <= w_vec_n;
            r_sa    <= w_sa_n;
        end
    end

`ifdef ALIGN_STICKY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= 1'b0;
        end else begin
            r_sticky <= w_sticky_n;
        end
    end
    assign out_grs = {r_vec[1:0], r_sticky};
`else
    assign out_grs = {r_vec[1:0], 1'b0};
`endif

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out_mant  = r_vec[VEC_W-1:2];
    assign out_zero  = (out_mant == '0) && (out_grs == '0);

endmodule

// File: tb/tb_align_shift_right.sv
// Bench for align_shift_right: directed literals plus random traffic
// against a plain-arithmetic shift model.
module tb_align_shift_right;

`ifdef ALIGN_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_mant;
    logic [7:0]  in_sa;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_mant;
    logic [2:0]  out_grs;
    logic        out_zero;

    align_shift_right dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_sa     (in_sa),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_grs   (out_grs),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] m;
        logic [2:0]  g;
    } res_t;

    res_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_acc = -100;

    // Exact shift of {mant,00} by min(sa,31); sticky = any bit dropped.
    function automatic res_t model(logic [23:0] m, logic [7:0] sa);
        longint unsigned v, s, lost;
        res_t r;
        v    = 64'(m) << 2;
        s    = (sa > 8'd31) ? 64'd31 : 64'(sa);
        lost = v & ((64'd1 << s) - 64'd1);
        v    = v >> s;
        r.m  = v[25:2];
        r.g  = {v[1], v[0], STK && (lost != 0)};
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: record accepts, retire outputs, check spacing.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && in_valid && in_ready) begin
            q.push_back(model(in_mant, in_sa));
            chk("accept_spacing", 32'(cyc - last_acc >= 7), 32'd1);
            last_acc <= cyc;
        end
        if (!rst && out_valid && out_ready && q.size() > 0)
            void'(q.pop_front());
    end

    // Compare process: every cycle outputs are meaningful.
    always @(negedge clk) begin
        if (!rst) begin
            chk("ready_valid_excl", 32'(in_ready & out_valid), 32'd0);
            if (out_valid) begin
                chk("out_pending", 32'(q.size()), 32'd1);
                if (q.size() > 0) begin
                    chk("model_mant", 32'(out_mant), 32'(q[0].m));
                    chk("model_grs", 32'(out_grs), 32'(q[0].g));
                    chk("model_zero", 32'(out_zero),
                        32'(q[0].m == 0 && q[0].g == 0));
                end
            end
        end
    end

    task automatic send(input logic [23:0] m, input logic [7:0] sa,
                        input int hold, input bit lit,
                        input logic [23:0] em, input logic [2:0] eg);
        int n;
        logic [23:0] sm;
        logic [2:0]  sg;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_mant   = m;
        in_sa     = sa;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'd6);
        if (lit) begin
            chk("lit_mant", 32'(out_mant), 32'(em));
            chk("lit_grs", 32'(out_grs), 32'(eg));
            chk("lit_zero", 32'(out_zero), 32'(em == 0 && eg == 0));
        end
        sm = out_mant;
        sg = out_grs;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_ready", 32'(in_ready), 32'd0);
            chk("hold_mant", 32'(out_mant), 32'(sm));
            chk("hold_grs", 32'(out_grs), 32'(sg));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_ready", 32'(in_ready), 32'd1);
        chk("idle_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mant   = '0;
        in_sa     = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_mant", 32'(out_mant), 32'd0);
        chk("rst_out_grs", 32'(out_grs), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd1);
        rst = 1'b0;

        send(24'h800000, 8'd1,   0, 1, 24'h400000, 3'b000);
        send(24'h800003, 8'd2,   0, 1, 24'h200000, 3'b110);
        send(24'h800007, 8'd3,   0, 1, 24'h100000, STK ? 3'b111 : 3'b110);
        send(24'hFFFFFF, 8'd24,  0, 1, 24'h000000, STK ? 3'b111 : 3'b110);
        send(24'hFFFFFF, 8'd200, 0, 1, 24'h000000, STK ? 3'b001 : 3'b000);
        send(24'hABCDEF, 8'd0,   0, 1, 24'hABCDEF, 3'b000);
        send(24'h123456, 8'd5,   3, 1, 24'h0091A2, STK ? 3'b101 : 3'b100);

        // Reset while the operand sits in S4.
        @(negedge clk);
        in_valid = 1'b1;
        in_mant  = 24'hC0FFEE;
        in_sa    = 8'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        q.delete();
        rst = 1'b0;
        out_ready = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_zero", 32'(out_zero), 32'd1);
        repeat (8) @(negedge clk);
        chk("midrst_no_output", 32'(out_valid), 32'd0);
        send(24'h9ABCDE, 8'd9, 0, 0, 24'h0, 3'b0);

        // Random traffic: in_valid held high, out_ready random.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            case ($urandom_range(0, 3))
                0: in_mant = 24'($urandom);
                1: in_mant = 24'h800000 | 24'($urandom_range(0, 255));
                2: in_mant = 24'($urandom) & 24'hFF0000;
                default: in_mant = 24'hFFFFFF;
            endcase
            if ($urandom_range(0, 9) == 0)
                in_sa = 8'($urandom);
            else
                in_sa = 8'($urandom_range(0, 34));
            out_ready = ($urandom_range(0, 2) != 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(negedge clk);
        chk("drain_empty", 32'(q.size()), 32'd0);
        chk("drain_idle", 32'(in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
